// File: rtl/alu_sweep_controller_if.sv
// Bundles the operand source, ALU drive/observe and capture-stream signals
// of the ALU sweep controller.
//   master : the controller (drives the ALU operands/op, capture stream, status)
//   slave  : the surroundings (switches, ALU instance, downstream sink)
interface alu_sweep_controller_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_result;
  logic         alu_n;
  logic         alu_z;
  logic         alu_c;
  logic         alu_v;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_op;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;
  logic [4:0]   zero_count;
  logic         busy;
  logic         done;

  modport master (
    input  start, a_in, b_in, alu_result, alu_n, alu_z, alu_c, alu_v, out_ready,
    output alu_a, alu_b, alu_op, out_valid, out_op, out_result, out_flags,
           zero_count, busy, done
  );

  modport slave (
    output start, a_in, b_in, alu_result, alu_n, alu_z, alu_c, alu_v, out_ready,
    input  alu_a, alu_b, alu_op, out_valid, out_op, out_result, out_flags,
           zero_count, busy, done
  );
endinterface

// File: rtl/alu_sweep_controller.sv
// ALU sweep controller: on start, latches one operand pair and steps the ALU
// through op codes 0..NUM_OPS-1. Each op is held SETTLE cycles, then the
// result and {N,Z,C,V} flags are captured and offered over valid/ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_sweep_controller_if.master (operand inputs, ALU drive and
//                observe, capture stream, zero_count/busy/done status)
module alu_sweep_controller #(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_OPS = 10,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_sweep_controller_if.master   bus
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [3:0]    LAST_OP     = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_alu_a;
  logic [N-1:0]  r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_out_valid;
  logic [3:0]    r_out_op;
  logic [N-1:0]  r_out_result;
  logic [3:0]    r_out_flags;
  logic [4:0]    r_zero_count;
  logic          r_busy;
  logic          r_done;

  // Sweep sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_out_valid  <= 1'b0;
      r_out_op     <= '0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_zero_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_alu_a      <= bus.a_in;
            r_alu_b      <= bus.b_in;
            r_alu_op     <= '0;
            r_zero_count <= '0;
            r_cnt        <= SETTLE_LOAD;
            r_busy       <= 1'b1;
            r_state      <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_out_op     <= r_alu_op;
            r_out_result <= bus.alu_result;
            r_out_flags  <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
            r_out_valid  <= 1'b1;
            // Saturate so a mis-parameterised sweep cannot wrap the count.
            if (bus.alu_z && (r_zero_count != 5'd31)) begin
              r_zero_count <= r_zero_count + 5'd1;
            end
            r_state <= S_PRESENT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_PRESENT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_alu_op == LAST_OP) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_alu_op <= r_alu_op + 4'd1;
              r_cnt    <= SETTLE_LOAD;
              r_state  <= S_DRIVE;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not sampled here; it must come in IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_op     = r_out_op;
  assign bus.out_result = r_out_result;
  assign bus.out_flags  = r_out_flags;
  assign bus.zero_count = r_zero_count;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_alu_sweep_controller.sv
// Testbench for alu_sweep_controller: behavioural ALU, scoreboard of expected
// captures, table of operand vectors, and hand sequences for backpressure,
// ignored inputs and reset mid-sweep.
module tb_alu_sweep_controller;

  localparam int unsigned N       = 4;
  localparam int unsigned NUM_OPS = 10;
  localparam int unsigned SETTLE  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alu_sweep_controller_if #(.N(N)) bus ();

  alu_sweep_controller #(
    .N(N), .NUM_OPS(NUM_OPS), .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [N-1:0] res;
    logic [3:0]   flags;   // {N,Z,C,V}
  } alu_out_t;

  typedef struct {
    logic [3:0] op;
    alu_out_t   o;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_add;
    logic [N-1:0] exp_sub;
    logic [3:0]   exp_f0;
    int           exp_zc;
    bit           rand_ready;
  } vec_t;

  // Reference ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT A,6 SHL A,7 SHR A,8 INC A,9 DEC A
  function automatic alu_out_t alu_model(input logic [3:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N:0]   w;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    alu_out_t     o;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[N-1:0];
        c = w[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = {a[N-2:0], 1'b0}; c = a[N-1]; end
      4'd7: begin r = {1'b0, a[N-1:1]}; c = a[0]; end
      4'd8: begin
        w = {1'b0, a} + {{N{1'b0}}, 1'b1};
        r = w[N-1:0];
        c = w[N];
      end
      default: r = a - {{(N-1){1'b0}}, 1'b1};
    endcase
    o.res   = r;
    o.flags = {r[N-1], (r == '0), c, v};
    return o;
  endfunction

  alu_out_t w_alu;
  always_comb begin
    w_alu          = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_result = w_alu.res;
    bus.alu_n      = w_alu.flags[3];
    bus.alu_z      = w_alu.flags[2];
    bus.alu_c      = w_alu.flags[1];
    bus.alu_v      = w_alu.flags[0];
  end

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_cap = 0;
  int           zc_model = 0;
  exp_t         sb_q[$];
  logic [N-1:0] cap_res [NUM_OPS];
  logic [3:0]   cap_flags [NUM_OPS];
  logic [N-1:0] lat_a, lat_b;
  bit           mon_lat_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture monitor: pops the scoreboard on every handshake and checks hold
  // behaviour while the sink stalls.
  exp_t         mon_e;
  bit           stall_prev = 1'b0;
  logic [3:0]   st_op, st_flags;
  logic [N-1:0] st_res;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("bp_valid_hold", bus.out_valid, 1);
        check("bp_op_hold", bus.out_op, st_op);
        check("bp_result_hold", bus.out_result, st_res);
        check("bp_flags_hold", bus.out_flags, st_flags);
      end
      if (mon_lat_en) begin
        check("alu_a_latched", bus.alu_a, lat_a);
        check("alu_b_latched", bus.alu_b, lat_b);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_capture: got op %0h with empty scoreboard", bus.out_op);
        end else begin
          mon_e = sb_q.pop_front();
          check("cap_op", bus.out_op, mon_e.op);
          check("cap_result", bus.out_result, mon_e.o.res);
          check("cap_flags", bus.out_flags, mon_e.o.flags);
          if (n_cap < NUM_OPS) begin
            cap_res[n_cap]   = bus.out_result;
            cap_flags[n_cap] = bus.out_flags;
          end
          n_cap++;
        end
        stall_prev = 1'b0;
      end else if (bus.out_valid) begin
        stall_prev = 1'b1;
        st_op      = bus.out_op;
        st_res     = bus.out_result;
        st_flags   = bus.out_flags;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge and queue the expected captures of the sweep.
  task automatic start_sweep(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    zc_model  = 0;
    n_cap     = 0;
    for (int op = 0; op < NUM_OPS; op++) begin
      exp_t e;
      e.op = 4'(op);
      e.o  = alu_model(4'(op), a, b);
      sb_q.push_back(e);
      if (e.o.flags[2]) zc_model++;
    end
    tick();
    bus.start  = 1'b0;
    lat_a      = a;
    lat_b      = b;
    mon_lat_en = 1'b1;
    check("start_busy", bus.busy, 1);
    check("start_alu_a", bus.alu_a, a);
    check("start_alu_b", bus.alu_b, b);
    check("start_alu_op", bus.alu_op, 0);
    check("start_zero_count", bus.zero_count, 0);
    check("start_out_valid", bus.out_valid, 0);
  endtask

  task automatic run_to_done(input int max_cyc, input bit rand_ready, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < max_cyc) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
  endtask

  // Called in the done cycle; checks end-of-sweep state and the IDLE return.
  task automatic finish_sweep();
    check("done_zero_count", bus.zero_count, zc_model);
    check("done_captures", n_cap, NUM_OPS);
    tick();
    check("after_done_pulse", bus.done, 0);
    check("after_done_busy", bus.busy, 0);
    check("after_done_zc_hold", bus.zero_count, zc_model);
    check("after_done_sb_empty", sb_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_alu_op"}, bus.alu_op, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_op"}, bus.out_op, 0);
    check({tag, "_out_result"}, bus.out_result, 0);
    check({tag, "_out_flags"}, bus.out_flags, 0);
    check({tag, "_zero_count"}, bus.zero_count, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  vec_t vecs [4];

  initial begin
    int           cyc;
    int           guard;
    int           cap_before;
    logic [3:0]   h_op;
    logic [N-1:0] h_res;

    vecs[0] = '{a:4'h2, b:4'hB, exp_add:4'hD, exp_sub:4'h7, exp_f0:4'b1000, exp_zc:0, rand_ready:1'b0};
    vecs[1] = '{a:4'h5, b:4'h5, exp_add:4'hA, exp_sub:4'h0, exp_f0:4'b1001, exp_zc:2, rand_ready:1'b1};
    vecs[2] = '{a:4'h0, b:4'h0, exp_add:4'h0, exp_sub:4'h0, exp_f0:4'b0100, exp_zc:7, rand_ready:1'b0};
    vecs[3] = '{a:4'hF, b:4'h1, exp_add:4'h0, exp_sub:4'hE, exp_f0:4'b0110, exp_zc:3, rand_ready:1'b1};

    bus.start     = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;

    // Reset with random inputs, then release with start low.
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.start     = 1'($urandom_range(0, 1));
      bus.a_in      = N'($urandom);
      bus.b_in      = N'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    check_all_zero("reset");
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("post_reset");

    // Operand table: full sweeps, alternately free-flowing and random backpressure.
    for (int i = 0; i < 4; i++) begin
      start_sweep(vecs[i].a, vecs[i].b);
      run_to_done(400, vecs[i].rand_ready, cyc);
      if (!vecs[i].rand_ready) check("sweep_cycles", cyc, NUM_OPS * (SETTLE + 1));
      check("cap0_result", cap_res[0], vecs[i].exp_add);
      check("cap0_flags", cap_flags[0], vecs[i].exp_f0);
      check("cap1_result", cap_res[1], vecs[i].exp_sub);
      check("table_zero_count", bus.zero_count, vecs[i].exp_zc);
      finish_sweep();
    end

    // Backpressure: hold the first capture for 5 cycles, then accept exactly one.
    bus.out_ready = 1'b0;
    start_sweep(4'h9, 4'h3);
    tick();
    check("first_valid_after_settle", bus.out_valid, 1);
    h_op  = bus.out_op;
    h_res = bus.out_result;
    repeat (5) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_out_op", bus.out_op, h_op);
      check("bp_out_result", bus.out_result, h_res);
      check("bp_alu_op", bus.alu_op, 0);
    end
    cap_before    = n_cap;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_valid_drop", bus.out_valid, 0);
    check("bp_one_capture", n_cap, cap_before + 1);
    check("bp_alu_op_next", bus.alu_op, 1);
    run_to_done(400, 1'b0, cyc);
    finish_sweep();

    // Ignored start / operand change mid-sweep, then start in the done cycle.
    start_sweep(4'h6, 4'h2);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    bus.start = 1'b1;
    bus.a_in  = 4'hF;
    bus.b_in  = 4'h0;
    tick();
    bus.start = 1'b0;
    check("ign_alu_a", bus.alu_a, 4'h6);
    check("ign_alu_op", bus.alu_op, 3);
    check("ign_busy", bus.busy, 1);
    run_to_done(400, 1'b0, cyc);
    check("ign_remaining_cycles", cyc, 14);
    bus.start = 1'b1;
    finish_sweep();
    bus.start = 1'b0;
    check("done_start_alu_op", bus.alu_op, 4'(NUM_OPS - 1));
    tick();
    check("done_start_busy", bus.busy, 0);
    check("done_start_valid", bus.out_valid, 0);

    // Reset during PRESENT of op 4, then a clean restart.
    start_sweep(4'h5, 4'h5);
    bus.out_ready = 1'b1;
    guard = 0;
    while (bus.alu_op != 4'd4 && guard < 100) begin
      tick();
      guard++;
    end
    check("rst_reach_op4", bus.alu_op, 4);
    bus.out_ready = 1'b0;
    tick();
    check("rst_present_valid", bus.out_valid, 1);
    check("rst_present_op", bus.out_op, 4);
    #2;
    rst_n      = 1'b0;
    mon_lat_en = 1'b0;
    #1;
    check("rst_async_valid", bus.out_valid, 0);
    check("rst_async_busy", bus.busy, 0);
    check("rst_async_alu_op", bus.alu_op, 0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_stay_idle", bus.busy, 0);
    start_sweep(4'h5, 4'h5);
    run_to_done(400, 1'b0, cyc);
    check("rst_restart_cycles", cyc, NUM_OPS * (SETTLE + 1));
    check("rst_restart_zc", bus.zero_count, 2);
    finish_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
